// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - instruction memory read bus between fetch stage and imem
interface instruction_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, IF/ID register, stall, redirect and range halt
module instruction_fetch_stage #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_stage_if.master imem,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    output logic [31:0]               pc,
    output logic [31:0]               if_id_pc4,
    output logic [31:0]               if_id_instr,
    output logic                      if_id_valid,
    output logic                      out_of_range,
    output logic [CNT_W-1:0]          fetch_count
);

    // 33-bit bound so a 4 GiB memory size cannot overflow the compare
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    logic [31:0]      pc_plus4;
    logic [31:0]      pc_next;
    logic [31:0]      pc4_next;
    logic [31:0]      instr_next;
    logic             valid_next;
    logic [CNT_W-1:0] count_next;
    logic             unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];

    assign imem.imem_addr = pc;
    assign out_of_range   = ({1'b0, pc} >= MEM_BYTES);
    assign pc_plus4       = pc + 32'd4;

    // Priority: redirect > stall > halt > fetch
    always_comb begin
        pc_next    = pc;
        pc4_next   = if_id_pc4;
        instr_next = if_id_instr;
        valid_next = if_id_valid;
        count_next = fetch_count;
        if (branch_taken) begin
            pc_next    = {branch_target[31:2], 2'b00};
            pc4_next   = 32'h0;
            instr_next = 32'h0;
            valid_next = 1'b0;
        end else if (stall) begin
            pc_next = pc;
        end else if (out_of_range) begin
            pc4_next   = 32'h0;
            instr_next = 32'h0;
            valid_next = 1'b0;
        end else begin
            pc_next    = pc_plus4;
            pc4_next   = pc_plus4;
            instr_next = imem.imem_data;
            valid_next = 1'b1;
            if (!(&fetch_count)) begin
                count_next = fetch_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_id_pc4   <= 32'h0;
            if_id_instr <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_next;
            if_id_pc4   <= pc4_next;
            if_id_instr <= instr_next;
            if_id_valid <= valid_next;
            fetch_count <= count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        oor;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        out_of_range;
    logic [15:0] fetch_count;
    logic        probe = 1'b0;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    instruction_fetch_stage_if imem ();

    // 64-word memory, word k holds 32'h1000_0000 + k
    assign imem.imem_data = (imem.imem_addr < 32'd256) ?
                            (32'h1000_0000 + {2'b00, imem.imem_addr[31:2]}) : 32'hDEAD_BEEF;

    instruction_fetch_stage #(.MEM_WORDS(64), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem(imem.master),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .out_of_range(out_of_range), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] p4, input logic [31:0] ins,
                                input logic v, input logic o, input logic [15:0] c);
        exp_t e;
        e.pc = p; e.pc4 = p4; e.instr = ins; e.valid = v; e.oor = o; e.cnt = c;
        return e;
    endfunction

    function automatic logic [31:0] w(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    task automatic step(input logic r, input logic st, input logic br, input logic [31:0] tgt,
                        input exp_t e, input string nm);
        @(negedge clk);
        rst = r; stall = st; branch_taken = br; branch_target = tgt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    task automatic probe_now(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        probe = 1'b1;
        #1 probe = 1'b0;
    endtask

    // Monitor: compares DUT state shortly after each clock edge or asynchronous probe
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (pc !== e.pc || if_id_pc4 !== e.pc4 || if_id_instr !== e.instr ||
                    if_id_valid !== e.valid || out_of_range !== e.oor || fetch_count !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got pc=%h pc4=%h instr=%h valid=%b oor=%b cnt=%h want pc=%h pc4=%h instr=%h valid=%b oor=%b cnt=%h",
                             nm, pc, if_id_pc4, if_id_instr, if_id_valid, out_of_range, fetch_count,
                             e.pc, e.pc4, e.instr, e.valid, e.oor, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t rs;
        rs = mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
        #2 probe_now(rs, "reset_state");

        step(1, 0, 0, 0, mk(32'd4, 32'd4, w(0), 1, 0, 16'd1), "fetch_w0");
        step(1, 0, 0, 0, mk(32'd8, 32'd8, w(1), 1, 0, 16'd2), "fetch_w1");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, mk(32'd8, 32'd8, w(1), 1, 0, 16'd2), "stall_hold");
        step(1, 0, 0, 0, mk(32'd12, 32'd12, w(2), 1, 0, 16'd3), "stall_release_w2");
        step(1, 0, 0, 0, mk(32'd16, 32'd16, w(3), 1, 0, 16'd4), "fetch_w3");
        step(1, 0, 0, 0, mk(32'd20, 32'd20, w(4), 1, 0, 16'd5), "fetch_w4");
        step(1, 1, 1, 32'h0000_0031, mk(32'd48, 32'h0, 32'h0, 0, 0, 16'd5), "branch_over_stall");
        step(1, 0, 0, 0, mk(32'd52, 32'd52, w(12), 1, 0, 16'd6), "after_branch_w12");
        for (int k = 13; k < 64; k++)
            step(1, 0, 0, 0, mk(32'(4 * (k + 1)), 32'(4 * (k + 1)), w(k), 1, (k == 63), 16'(k - 6)),
                 "sequential_run");
        for (int i = 0; i < 2; i++)
            step(1, 0, 0, 0, mk(32'd256, 32'h0, 32'h0, 0, 1, 16'd57), "halt_hold");
        step(1, 0, 1, 32'h0, mk(32'h0, 32'h0, 32'h0, 0, 0, 16'd57), "branch_leave_halt");
        step(1, 0, 0, 0, mk(32'd4, 32'd4, w(0), 1, 0, 16'd58), "resume_w0");
        step(1, 0, 1, 32'h0000_1003, mk(32'h1000, 32'h0, 32'h0, 0, 1, 16'd58), "branch_out_of_range");
        step(1, 0, 0, 0, mk(32'h1000, 32'h0, 32'h0, 0, 1, 16'd58), "oor_target_halt");
        step(1, 0, 1, 32'h0, mk(32'h0, 32'h0, 32'h0, 0, 0, 16'd58), "branch_back_zero");
        for (int k = 0; k < 10; k++)
            step(1, 0, 0, 0, mk(32'(4 * (k + 1)), 32'(4 * (k + 1)), w(k), 1, 0, 16'(59 + k)), "run_to_40");

        #3 rst = 1'b0;
        probe_now(rs, "async_reset_immediate");
        step(0, 0, 0, 0, rs, "reset_held_over_edge");
        step(1, 0, 0, 0, mk(32'd4, 32'd4, w(0), 1, 0, 16'd1), "restart_w0");

        #3 force dut.fetch_count = 16'hFFFE;
        #1 release dut.fetch_count;
        step(1, 0, 0, 0, mk(32'd8, 32'd8, w(1), 1, 0, 16'hFFFF), "count_reach_max");
        step(1, 0, 0, 0, mk(32'd12, 32'd12, w(2), 1, 0, 16'hFFFF), "count_saturate_1");
        step(1, 0, 0, 0, mk(32'd16, 32'd16, w(3), 1, 0, 16'hFFFF), "count_saturate_2");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline; the initiator side of the instruction memory read interface.
- Owns the program counter and drives the word-aligned instruction address to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register, and handles stall, branch redirect/flush and out-of-range fetch.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in instruction memory; valid byte addresses are 0 .. MEM_WORDS*4-4.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- imem_addr  output  32  byte address to instruction memory; equals pc.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hazard-unit stall; holds PC and IF/ID.
- branch_taken  input  1  redirect request from the branch resolution stage.
- branch_target  input  32  byte address of the redirect target.
- pc  output  32  current program counter.
- if_id_pc4  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID; 32'h0 when a bubble is held.
- if_id_valid  output  1  IF/ID holds a real instruction.
- out_of_range  output  1  PC is at or beyond MEM_WORDS*4; fetching is halted.
- fetch_count  output  CNT_W  number of valid instructions latched into IF/ID, saturating.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately and overrides clk):
  - pc = RESET_PC; if_id_pc4 = 0; if_id_instr = 0; if_id_valid = 0; fetch_count = 0.
  - out_of_range is derived combinationally from pc, so it is 0 for any in-range RESET_PC.
  - Outputs hold these values for as long as rst stays low.
  - Asserting reset mid-operation discards the in-flight instruction with no partial update.
- imem_addr = pc, combinational. Instruction latency is zero cycles to the imem_data port and one clock edge into IF/ID.
- out_of_range = (pc >= MEM_WORDS*4), combinational, unsigned compare.
- Per rising clk edge with rst high, modes in strict priority order:
  1. REDIRECT (branch_taken=1; wins over stall and out_of_range):
     - pc <= {branch_target[31:2], 2'b00}; low bits are forced to zero.
     - IF/ID is flushed: if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= 0.
     - fetch_count is unchanged.
  2. STALL (stall=1): pc, IF/ID and fetch_count all hold.
  3. HALT (out_of_range=1):
     - pc holds; a bubble is inserted (if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= 0).
     - fetch_count holds.
  4. FETCH (otherwise):
     - pc <= pc + 4, with a 32-bit modulo wrap.
     - if_id_instr <= imem_data; if_id_pc4 <= pc + 4; if_id_valid <= 1.
     - fetch_count <= fetch_count + 1, saturating at all-ones.
- Leaving HALT: only via REDIRECT to an in-range target, or via reset.
- Simultaneous branch_taken and stall: REDIRECT applies; the stalled instruction in IF/ID is squashed.
- A branch_target that is out of range is accepted. The next cycle then enters HALT, with out_of_range=1 visible immediately after the edge.
- The block has no internal combinational path from stall or branch_taken to imem_addr; imem_addr changes only on clk or rst.
- Instruction memory contents are loaded by its own reset handling. The first FETCH edge after rst deasserts reads word RESET_PC>>2.

Test Plan:
- Reset then 4 free-running clocks, memory word k = 32'h1000_0000+k:
  - -> pc 0,4,8,12,16.
  - -> if_id_instr 32'h1000_0000..32'h1000_0003 with if_id_pc4 4..16, if_id_valid=1, fetch_count=4.
- At pc=8, assert stall for 3 cycles:
  - -> pc stays 8, and if_id_instr holds word 1 for 3 cycles.
  - -> on release, word 2 is latched with if_id_pc4=12; fetch_count does not increment during the stall.
- At pc=20, branch_taken=1 with branch_target=32'h0000_0031 and stall=1 in the same cycle:
  - -> pc=48, if_id_valid=0, if_id_instr=0.
  - -> the next edge latches word 12 with if_id_pc4=52.
- Run sequentially to pc=252 with MEM_WORDS=64:
  - -> word 63 is latched and pc=256, out_of_range=1.
  - -> subsequent edges keep pc=256 and if_id_valid=0, and fetch_count stops.
  - -> a later branch to 0 clears out_of_range and resumes at word 0.
- Drop rst low asynchronously between clock edges at pc=40:
  - -> pc=0, if_id_valid=0, fetch_count=0 immediately, before the next clk edge.
  - -> after release, fetch restarts at word 0.
- Force fetch_count to all-ones minus 1, then run 3 fetches:
  - -> fetch_count saturates at all-ones (16'hFFFF), with no wrap.
